// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and helpers for the address-request arbiter
package arb_pkg;

    localparam int ADDR_MAX_W = 64;
    localparam int SRC_MAX_W  = 4;

    typedef enum logic {
        FIXED       = 1'b0,
        ROUND_ROBIN = 1'b1
    } arb_mode_e;

    // Widest entry the arbiter can carry; instances store only W+SW bits of it.
    typedef struct packed {
        logic [ADDR_MAX_W-1:0] addr;
        logic [SRC_MAX_W-1:0]  src;
    } arb_entry_t;

    function automatic int SRC_W(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arb_queue2.sv
// rtl/arb_queue2.sv - two-entry registered FIFO with occupancy count
module arb_queue2 #(
    parameter int DW = 8
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          enq_valid_i,
    input  logic [DW-1:0] enq_data_i,
    output logic          enq_ready_o,
    output logic          deq_valid_o,
    input  logic          deq_ready_i,
    output logic [DW-1:0] deq_data_o,
    output logic [1:0]    count_o
);

    logic [DW-1:0] mem_q [2];
    logic          head_q, head_d;
    logic          tail_q, tail_d;
    logic [1:0]    count_q, count_d;
    logic          enq, deq;

    assign enq_ready_o = (count_q != 2'd2);
    assign deq_valid_o = (count_q != 2'd0);
    assign enq         = enq_valid_i & enq_ready_o;
    assign deq         = deq_valid_o & deq_ready_i;

    // Head data comes straight from storage, never from the enqueue path.
    assign deq_data_o  = mem_q[head_q];
    assign count_o     = count_q;

    always_comb begin
        head_d  = head_q ^ deq;
        tail_d  = tail_q ^ enq;
        count_d = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (enq) begin
            mem_q[tail_q] <= enq_data_i;
        end
    end

endmodule

// File: rtl/addr_rr_arbiter.sv
// rtl/addr_rr_arbiter.sv - N-channel address arbiter (round-robin or fixed) into a 2-entry queue
module addr_rr_arbiter
    import arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = 32,
    parameter int RR = 1,
    parameter int SW = SRC_W(N)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   io_in_valid,
    input  logic [N*W-1:0] io_in_bits_address,
    output logic [N-1:0]   io_in_ready,
    output logic           io_out_valid,
    input  logic           io_out_ready,
    output logic [W-1:0]   io_out_bits_address,
    output logic [SW-1:0]  io_out_bits_source,
    output logic [1:0]     io_count
);

    localparam arb_mode_e MODE = (RR != 0) ? ROUND_ROBIN : FIXED;

    typedef struct packed {
        logic [W-1:0]  addr;
        logic [SW-1:0] src;
    } entry_t;

    logic [SW-1:0] ptr_q, ptr_d;
    logic [SW-1:0] cand;
    logic [SW-1:0] grant_idx;
    logic [N-1:0]  grant;
    logic          grant_any;
    logic          enq_ready;
    logic          enq;
    entry_t        enq_entry;
    entry_t        head_entry;

    // Scan N candidates; RR starts one past the last accepted channel.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            if (MODE == ROUND_ROBIN) begin
                cand = SW'((int'(ptr_q) + k + 1) % N);
            end else begin
                cand = SW'(k);
            end
            if (!grant_any && io_in_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign io_in_ready = grant & {N{enq_ready}};
    assign enq         = grant_any & enq_ready;

    assign enq_entry.addr = io_in_bits_address[int'(grant_idx)*W +: W];
    assign enq_entry.src  = grant_idx;

    // Pointer moves only on an actual enqueue so a stalled winner keeps its grant.
    always_comb begin
        ptr_d = ptr_q;
        if ((MODE == ROUND_ROBIN) && enq) begin
            ptr_d = grant_idx;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= SW'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

    arb_queue2 #(
        .DW ($bits(entry_t))
    ) u_queue (
        .clock_i     (clock),
        .reset_i     (reset),
        .enq_valid_i (grant_any),
        .enq_data_i  (enq_entry),
        .enq_ready_o (enq_ready),
        .deq_valid_o (io_out_valid),
        .deq_ready_i (io_out_ready),
        .deq_data_o  (head_entry),
        .count_o     (io_count)
    );

    assign io_out_bits_address = head_entry.addr;
    assign io_out_bits_source  = head_entry.src;

endmodule

// File: tb/tb_addr_rr_arbiter.sv
// tb/tb_addr_rr_arbiter.sv - directed self-checking bench for addr_rr_arbiter
module tb_addr_rr_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int SW = 2;

    logic           clock;
    logic           reset;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_addr;
    logic           out_ready;

    logic [N-1:0]   r_in_ready, f_in_ready;
    logic           r_out_valid, f_out_valid;
    logic [W-1:0]   r_out_addr, f_out_addr;
    logic [SW-1:0]  r_out_src, f_out_src;
    logic [1:0]     r_count, f_count;

    int n_checks;
    int n_errors;

    addr_rr_arbiter #(.N(N), .W(W), .RR(1)) dut_rr (
        .clock               (clock),
        .reset               (reset),
        .io_in_valid         (in_valid),
        .io_in_bits_address  (in_addr),
        .io_in_ready         (r_in_ready),
        .io_out_valid        (r_out_valid),
        .io_out_ready        (out_ready),
        .io_out_bits_address (r_out_addr),
        .io_out_bits_source  (r_out_src),
        .io_count            (r_count)
    );

    addr_rr_arbiter #(.N(N), .W(W), .RR(0)) dut_fp (
        .clock               (clock),
        .reset               (reset),
        .io_in_valid         (in_valid),
        .io_in_bits_address  (in_addr),
        .io_in_ready         (f_in_ready),
        .io_out_valid        (f_out_valid),
        .io_out_ready        (out_ready),
        .io_out_bits_address (f_out_addr),
        .io_out_bits_source  (f_out_src),
        .io_count            (f_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic set_addr(input int ch, input logic [W-1:0] a);
        in_addr[ch*W +: W] = a;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        in_valid  = '0;
        in_addr   = '0;
        out_ready = 1'b0;

        // 1: reset state, then all channels valid in RR mode
        cyc();
        check("rst_count", 64'(r_count), 64'd0);
        check("rst_out_valid", 64'(r_out_valid), 64'd0);
        check("rst_in_ready", 64'(r_in_ready), 64'd0);
        reset = 1'b0;
        for (int i = 0; i < N; i++) set_addr(i, W'(32'h100 * i));
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        check("t1_ready_c0", 64'(r_in_ready), 64'b0001);
        for (int k = 1; k <= 8; k++) begin
            cyc();
            check("t1_valid", 64'(r_out_valid), 64'd1);
            check("t1_src", 64'(r_out_src), 64'((k - 1) % 4));
            check("t1_addr", 64'(r_out_addr), 64'(32'h100 * ((k - 1) % 4)));
            check("t1_ready", 64'(r_in_ready), 64'(4'b0001 << (k % 4)));
            check("t1_count", 64'(r_count), 64'd1);
        end

        // 2: fixed priority, channel 0 always wins
        do_reset();
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        check("t2_ready_c0", 64'(f_in_ready), 64'b0001);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            check("t2_valid", 64'(f_out_valid), 64'd1);
            check("t2_src", 64'(f_out_src), 64'd0);
            check("t2_ready", 64'(f_in_ready), 64'b0001);
        end
        in_valid = 4'b1110;
        #1;
        check("t2_ready_drop0", 64'(f_in_ready), 64'b0010);

        // 3: backpressure on channel 2
        do_reset();
        out_ready = 1'b0;
        in_valid  = 4'b0100;
        set_addr(2, 32'hDEAD_0000);
        #1;
        check("t3_ready0", 64'(r_in_ready), 64'b0100);
        check("t3_count0", 64'(r_count), 64'd0);
        check("t3_valid0", 64'(r_out_valid), 64'd0);
        cyc();
        check("t3_count1", 64'(r_count), 64'd1);
        check("t3_head1", 64'(r_out_addr), 64'h0000_0000_DEAD_0000);
        check("t3_src1", 64'(r_out_src), 64'd2);
        check("t3_ready1", 64'(r_in_ready), 64'b0100);
        set_addr(2, 32'hDEAD_0001);
        cyc();
        check("t3_count2", 64'(r_count), 64'd2);
        check("t3_ready_full", 64'(r_in_ready), 64'b0000);
        set_addr(2, 32'hDEAD_0002);
        repeat (3) begin
            cyc();
            check("t3_hold_addr", 64'(r_out_addr), 64'h0000_0000_DEAD_0000);
            check("t3_hold_count", 64'(r_count), 64'd2);
            check("t3_hold_ready", 64'(r_in_ready), 64'b0000);
        end
        out_ready = 1'b1;
        cyc();
        check("t3_drain1_count", 64'(r_count), 64'd1);
        check("t3_drain1_addr", 64'(r_out_addr), 64'h0000_0000_DEAD_0001);
        check("t3_drain1_ready", 64'(r_in_ready), 64'b0100);
        cyc();
        check("t3_swap_count", 64'(r_count), 64'd1);
        check("t3_swap_addr", 64'(r_out_addr), 64'h0000_0000_DEAD_0002);
        check("t3_swap_src", 64'(r_out_src), 64'd2);
        in_valid = 4'b0000;
        cyc();
        check("t3_empty_count", 64'(r_count), 64'd0);
        check("t3_empty_valid", 64'(r_out_valid), 64'd0);

        // 4: stalled winner ch1 keeps its grant while the queue is full
        do_reset();
        out_ready = 1'b0;
        in_valid  = 4'b0001;
        cyc();
        cyc();
        in_valid = 4'b1110;
        #1;
        check("t4_full_count", 64'(r_count), 64'd2);
        check("t4_full_ready", 64'(r_in_ready), 64'b0000);
        repeat (5) begin
            cyc();
            check("t4_stall_ready", 64'(r_in_ready), 64'b0000);
            check("t4_stall_count", 64'(r_count), 64'd2);
            check("t4_stall_src", 64'(r_out_src), 64'd0);
        end
        out_ready = 1'b1;
        cyc();
        check("t4_open_count", 64'(r_count), 64'd1);
        check("t4_open_ready", 64'(r_in_ready), 64'b0010);
        cyc();
        check("t4_win_src", 64'(r_out_src), 64'd1);
        check("t4_win_count", 64'(r_count), 64'd1);
        check("t4_next_ready", 64'(r_in_ready), 64'b0100);
        in_valid = 4'b0000;

        // 5: sparse requests and pointer wrap
        do_reset();
        out_ready = 1'b1;
        in_valid  = 4'b1000;
        #1;
        check("t5_ready_c3", 64'(r_in_ready), 64'b1000);
        cyc();
        check("t5_src3", 64'(r_out_src), 64'd3);
        check("t5_valid3", 64'(r_out_valid), 64'd1);
        in_valid = 4'b0001;
        #1;
        check("t5_ready_c0", 64'(r_in_ready), 64'b0001);
        cyc();
        check("t5_src0", 64'(r_out_src), 64'd0);
        in_valid = 4'b1001;
        #1;
        check("t5_ready_after_wrap", 64'(r_in_ready), 64'b1000);
        in_valid = 4'b0000;

        // 6: reset while the queue is full
        do_reset();
        out_ready = 1'b0;
        in_valid  = 4'b0001;
        cyc();
        cyc();
        check("t6_pre_count", 64'(r_count), 64'd2);
        in_valid = 4'b1111;
        reset    = 1'b1;
        cyc();
        check("t6_rst_count", 64'(r_count), 64'd0);
        check("t6_rst_valid", 64'(r_out_valid), 64'd0);
        check("t6_rst_ready", 64'(r_in_ready), 64'b0001);
        reset     = 1'b0;
        out_ready = 1'b1;
        cyc();
        check("t6_first_src", 64'(r_out_src), 64'd0);
        check("t6_first_valid", 64'(r_out_valid), 64'd1);
        check("t6_next_ready", 64'(r_in_ready), 64'b0010);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/addr_rr_arbiter.md
# addr_rr_arbiter

Parametrised N-channel address-request arbiter feeding a single downstream port, with selectable round-robin or fixed-priority grant and a 2-entry registered output queue. It replaces the combinational 2-input priority arbiters in the memory-request path where more requesters, fairness and a timing break are needed. Accepted requests carry the winning channel index so responses can be routed back.

## Interface
Parameters:
- `N`, 4: number of input channels, 2..16.
- `W`, 32: address width, 1..64.
- `RR`, 1: 1 selects round-robin arbitration; 0 selects fixed priority, where the lowest index wins.
- `SW`, `$clog2(N)`: source-index width. Derived; the minimum is 1.

Ports:
- `clock`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high.
- `io_in_valid`, in, N: per-channel request valid.
- `io_in_bits_address`, in, N*W: channel i occupies bits [i*W +: W].
- `io_in_ready`, out, N: per-channel accept.
- `io_out_valid`, out, 1: queue head valid.
- `io_out_ready`, in, 1: downstream accept.
- `io_out_bits_address`, out, W: head address.
- `io_out_bits_source`, out, SW: channel index of the head entry.
- `io_count`, out, 2: queue occupancy, 0..2.

## Operation
- **Grant.** Exactly one channel is granted when any `io_in_valid` bit is set.
  - The grant depends only on the valids and the pointer, never on `io_out_ready`.
  - `io_in_ready[i] = grant[i] & ~full`, where full means count == 2.
  - Non-granted channels see ready = 0.
- **Round-robin mode.** Search order starts at `(ptr+1) mod N` and wraps.
  - `ptr` loads the granted index only when an enqueue happens (`io_in_valid[g] & io_in_ready[g]`).
  - `ptr` holds otherwise, so a stalled winner keeps its grant until accepted or withdrawn.
- **Fixed-priority mode.** The lowest valid index wins. `ptr` is unused and held at reset value.
- **Enqueue.** `{address[g], g}` is written to the queue tail.
- **Dequeue.** Occurs when `io_out_valid & io_out_ready`.
- **Simultaneous enqueue and dequeue.**
  - At count 1: count stays 1, head becomes the new entry.
  - At count 2: enqueue is impossible because ready is low. The dequeue proceeds and count goes to 1.
- **Empty queue.** `io_out_valid` = 0. `io_out_bits_*` are don't-care but must be driven from the storage registers, not through a combinational input path.
- **Full throughput.** With `io_out_ready` held high, one request per cycle is sustained indefinitely.
- **Reset.** All outputs reach their reset values in the cycle after `reset` is sampled high, including mid-traffic; queued entries are dropped.
  - `count` = 0.
  - `ptr` = N-1, so channel 0 has first priority after reset.
  - `io_out_valid` = 0.
  - `io_count` = 0.
  - `io_in_ready` follows the grant, since full = 0.
- **Address storage.** Stored unmodified; no width conversion.

## Timing
- **Latency.** A request accepted at edge t appears on `io_out_*` after edge t; it is visible in cycle t+1. There is no combinational path from `io_in_*` to `io_out_*`.
- **Combinational paths.** `io_in_ready` depends combinationally on `io_in_valid`, `ptr` and count. It does not depend on `io_out_ready`, which keeps loops out of chained arbiters.
- **Protocol.** Upstream must hold valid and address stable until accepted. The arbiter guarantees that a held request is granted within N-1 other accepts in RR mode.

## Structure
- **Shared package `arb_pkg`.**
  - `SRC_W(n)` clog2 helper with a minimum of 1.
  - Enum `arb_mode_e` {FIXED, ROUND_ROBIN}.
  - Entry struct type `{addr, src}`.
- **Sub-module `arb_queue2`.** 2-entry FIFO, parametrised on entry width. Holds head/tail pointer and count logic, and exports `enq_ready`, `deq_valid`, count.
- **Top level.** Holds the grant logic and `ptr`.

## Test plan
1. **Reset, then all inputs valid.** N=4, RR=1, `io_out_ready`=1, addresses 0x100·i. Required output sources are 0,1,2,3,0,… with one per cycle; the first output appears in cycle 1.
2. **Fixed priority.** RR=0, all valid. Source 0 repeats every cycle; channels 1–3 never see ready until ch0 drops.
3. **Backpressure.** `io_out_ready`=0 with ch2 valid, address 0xDEAD_0000.
   - After 2 accepts, count=2 and `io_in_ready`=0.
   - The held head address stays stable.
   - Raising ready drains both entries in order, and the third request enqueues in the same cycle count drops to 1.
4. **Stalled winner.** RR, queue full, ch1 is the granted channel. `ptr` and grant stay unchanged across 5 stall cycles; no other channel is accepted.
5. **Sparse and wrap.** Only ch3 then ch0 valid. Expected sources are 3 then 0, with `ptr` wrapping from 3 to 0 correctly.
6. **Reset mid-operation.** Assert reset with count=2. The next cycle shows count=0, `io_out_valid`=0 and `ptr`=N-1; the first grant afterwards goes to ch0.
